ysyx_24100005_lsu: RTL

Multicycle load/store unit between the core's execute stage and the data-memory port, replacing the single-cycle combinational memory read path. Accepts one load/store per handshake, performs byte/half/word(/double) alignment, write-mask generation and sign/zero extension, and holds a request/acknowledge transaction on the memory side for arbitrary latency. Parametrised in data width (RV32/RV64); misalignment detection is a compile-time option.

---
 rtl/ysyx_24100005_lsu_pkg.sv | 26 ++
 rtl/ysyx_24100005_lsu_align.sv | 70 +++++++
 rtl/ysyx_24100005_lsu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_lsu_pkg.sv
// rtl/ysyx_24100005_lsu_pkg.sv - shared types and constants for the load/store unit
package ysyx_24100005_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RSP  = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int F3_UNSIGNED_BIT = 2;

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        case (size)
            SZ_H:    is_misaligned = addr_lo[0];
            SZ_W:    is_misaligned = |addr_lo[1:0];
            SZ_D:    is_misaligned = |addr_lo;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// rtl/ysyx_24100005_lsu_align.sv - byte-lane mask/shift for stores and extract/extend for loads
module ysyx_24100005_lsu_align
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NB    = XLEN / 8,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [OFF_W-1:0] off_i,
    input  logic [1:0]       size_i,
    input  logic             uns_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  logic [XLEN-1:0]  rdata_i,
    output logic [NB-1:0]    wmask_o,
    output logic [XLEN-1:0]  wdata_o,
    output logic [XLEN-1:0]  rdata_o
);

    logic [NB-1:0]   base_mask;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] low_mask;
    logic            sign;

    always_comb begin
        base_mask = '1;
        case (size_i)
            SZ_B:    base_mask = NB'(1);
            SZ_H:    base_mask = NB'(3);
            SZ_W:    base_mask = NB'(15);
            default: base_mask = '1;
        endcase
    end

    // Lanes shifted past the top of the word are simply dropped: no second beat.
    assign wmask_o = base_mask << off_i;
    assign wdata_o = wdata_i << {off_i, 3'b000};

    assign raw = rdata_i >> {off_i, 3'b000};

    always_comb begin
        low_mask = '1;
        sign     = 1'b0;
        case (size_i)
            SZ_B: begin
                low_mask = XLEN'(8'hFF);
                sign     = raw[7];
            end
            SZ_H: begin
                low_mask = XLEN'(16'hFFFF);
                sign     = raw[15];
            end
            SZ_W: begin
                if (XLEN > 32) begin
                    low_mask = XLEN'(32'hFFFF_FFFF);
                    sign     = raw[31];
                end
            end
            default: begin
                low_mask = '1;
                sign     = 1'b0;
            end
        endcase
        if (uns_i) begin
            sign = 1'b0;
        end
    end

    assign rdata_o = (raw & low_mask) | ({XLEN{sign}} & ~low_mask);

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// rtl/ysyx_24100005_lsu.sv - multicycle load/store unit; YSYX_LSU_MISALIGN_EN enables misalignment errors
module ysyx_24100005_lsu
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [NB-1:0]     mem_wmask_q;
    logic              wen_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;

    logic              in_idle;
    logic [OFF_W-1:0]  off_sel;
    logic [1:0]        size_sel;
    logic [NB-1:0]     al_wmask;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    logic              size_illegal;
    logic              misaligned;
    logic              req_err;

    // In IDLE the aligner works on the incoming request, afterwards on the latched one.
    assign in_idle  = (state_q == ST_IDLE);
    assign off_sel  = in_idle ? req_addr[OFF_W-1:0] : off_q;
    assign size_sel = in_idle ? req_funct3[1:0] : funct3_q[1:0];

    ysyx_24100005_lsu_align #(.XLEN(XLEN)) u_align (
        .off_i   (off_sel),
        .size_i  (size_sel),
        .uns_i   (funct3_q[F3_UNSIGNED_BIT]),
        .wdata_i (req_wdata),
        .rdata_i (mem_rdata),
        .wmask_o (al_wmask),
        .wdata_o (al_wdata),
        .rdata_o (al_rdata)
    );

    assign size_illegal = (XLEN == 32) && (req_funct3[1:0] == SZ_D);

`ifdef YSYX_LSU_MISALIGN_EN
    assign misaligned = is_misaligned(req_addr[2:0], req_funct3[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = size_illegal | misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            wen_q       <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q       <= req_wen;
                        funct3_q    <= req_funct3;
                        off_q       <= req_addr[OFF_W-1:0];
                        req_ready_q <= 1'b0;
                        if (req_err) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_MEM;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_wen;
                            mem_addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata_q <= req_wen ? al_wdata : '0;
                            mem_wmask_q <= req_wen ? al_wmask : '0;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        state_q     <= ST_RSP;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        mem_wmask_q <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= wen_q ? '0 : al_rdata;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;

endmodule
